// File: rtl/chip_idle_pkg.sv
// ---------------------------------------------------------------------------
// chip_idle_pkg
// Shared types for the chip idle / clock-gating controller.
//   chip_idle_state_e : controller FSM states, 3-bit encoding that is also
//                       driven out on state_o for debug visibility.
// ---------------------------------------------------------------------------
package chip_idle_pkg;

    localparam int STATE_W = 3;

    // The encoding is visible on state_o, so the values are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 3'd0,
        ST_FILTER   = 3'd1,
        ST_GATE_REQ = 3'd2,
        ST_GATED    = 3'd3,
        ST_UNGATE   = 3'd4
    } chip_idle_state_e;

endpackage

// File: rtl/chip_idle_gen.sv
// ---------------------------------------------------------------------------
// chip_idle_gen
// Combinational chip-idle condition from CPU and cache-bank status lanes.
// A CPU is idle when it is in WFI, in WFE, or held in reset.
// A bank is idle when it reports idle or is held in reset.
// Ports:
//   i_cpu_wfi/i_cpu_wfe/i_cpu_rstn : per-CPU status (N_CPU lanes)
//   i_bank_idle/i_bank_rstn        : per-bank status (N_BANK lanes)
//   o_idle                         : 1 when every CPU and every bank is idle
// ---------------------------------------------------------------------------
module chip_idle_gen #(
    parameter int N_CPU  = 5,
    parameter int N_BANK = 4
) (
    input  logic [N_CPU-1:0]  i_cpu_wfi,
    input  logic [N_CPU-1:0]  i_cpu_wfe,
    input  logic [N_CPU-1:0]  i_cpu_rstn,
    input  logic [N_BANK-1:0] i_bank_idle,
    input  logic [N_BANK-1:0] i_bank_rstn,
    output logic              o_idle
);

    logic [N_CPU-1:0]  w_cpu_idle;
    logic [N_BANK-1:0] w_bank_idle;

    assign w_cpu_idle  = i_cpu_wfi | i_cpu_wfe | ~i_cpu_rstn;
    assign w_bank_idle = i_bank_idle | ~i_bank_rstn;
    assign o_idle      = (&w_cpu_idle) & (&w_bank_idle);

endmodule

// File: rtl/chip_idle_ctrl.sv
// ---------------------------------------------------------------------------
// chip_idle_ctrl
// Always-on controller that gates the chip clock once the chip has been idle
// for a programmable number of cycles, using a four-phase req/ack handshake
// with the clock controller, and ungates on wake or renewed activity.
// Ports:
//   clk, rstn                     : always-on clock, async active-low reset
//   cpu_wfi/cpu_wfe/cpu_rstn      : per-CPU status lanes
//   bank_idle/bank_rstn           : per-bank status lanes
//   cfg_en                        : gating enable
//   cfg_idle_thresh               : idle cycles required before requesting
//   wake_irq                      : OR of pending wake sources
//   clk_gate_ack                  : clock controller acknowledge
//   clk_gate_req                  : gating request (four-phase)
//   chip_is_idle                  : registered idle flag
//   chip_gated                    : high while gated
//   gate_cnt                      : completed gate entries, saturating
//   state_o                       : FSM state, for debug
// ---------------------------------------------------------------------------
module chip_idle_ctrl
    import chip_idle_pkg::*;
#(
    parameter int CPU_IDLE_N_CPU  = 5,
    parameter int CPU_IDLE_N_BANK = 4,
    parameter int IDLE_CNT_W      = 16,
    parameter int GATE_CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [CPU_IDLE_N_CPU-1:0]  cpu_wfi,
    input  logic [CPU_IDLE_N_CPU-1:0]  cpu_wfe,
    input  logic [CPU_IDLE_N_CPU-1:0]  cpu_rstn,
    input  logic [CPU_IDLE_N_BANK-1:0] bank_idle,
    input  logic [CPU_IDLE_N_BANK-1:0] bank_rstn,
    input  logic                       cfg_en,
    input  logic [IDLE_CNT_W-1:0]      cfg_idle_thresh,
    input  logic                       wake_irq,
    input  logic                       clk_gate_ack,
    output logic                       clk_gate_req,
    output logic                       chip_is_idle,
    output logic                       chip_gated,
    output logic [GATE_CNT_W-1:0]      gate_cnt,
    output logic [STATE_W-1:0]         state_o
);

    localparam logic [IDLE_CNT_W-1:0] IDLE_ONE = {{(IDLE_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_CNT_W-1:0] GATE_ONE = {{(GATE_CNT_W-1){1'b0}}, 1'b1};

    logic                  w_idle_comb;
    logic                  w_abort;
    logic                  w_gate_inc;
    logic [IDLE_CNT_W-1:0] w_idle_cnt_nxt;
    chip_idle_state_e      w_state_nxt;

    logic                  r_chip_is_idle;
    logic [IDLE_CNT_W-1:0] r_idle_cnt;
    logic [GATE_CNT_W-1:0] r_gate_cnt;
    chip_idle_state_e      r_state;

    chip_idle_gen #(
        .N_CPU  (CPU_IDLE_N_CPU),
        .N_BANK (CPU_IDLE_N_BANK)
    ) u_idle_gen (
        .i_cpu_wfi   (cpu_wfi),
        .i_cpu_wfe   (cpu_wfe),
        .i_cpu_rstn  (cpu_rstn),
        .i_bank_idle (bank_idle),
        .i_bank_rstn (bank_rstn),
        .o_idle      (w_idle_comb)
    );

    // Abort is built from the registered idle flag, so status changes reach
    // the FSM one cycle after they appear on the input lanes.
    assign w_abort = ~r_chip_is_idle | ~cfg_en | wake_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_chip_is_idle <= 1'b0;
            r_state        <= ST_RUN;
            r_idle_cnt     <= '0;
            r_gate_cnt     <= '0;
        end else begin
            r_chip_is_idle <= w_idle_comb;
            r_state        <= w_state_nxt;
            r_idle_cnt     <= w_idle_cnt_nxt;
            if (w_gate_inc && (r_gate_cnt != '1)) begin
                r_gate_cnt <= r_gate_cnt + GATE_ONE;
            end
        end
    end

    // The filter counter only holds a non-zero value while in FILTER; every
    // other path clears it so each new filter period starts from zero.
    // Once a request is raised it is held until the ack arrives, even if an
    // abort shows up meanwhile, which keeps the handshake four-phase.
    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = '0;
        w_gate_inc     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!w_abort) begin
                    w_state_nxt = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (w_abort) begin
                    w_state_nxt = ST_RUN;
                end else if (r_idle_cnt >= cfg_idle_thresh) begin
                    w_state_nxt = ST_GATE_REQ;
                end else if (r_idle_cnt == '1) begin
                    w_idle_cnt_nxt = r_idle_cnt;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + IDLE_ONE;
                end
            end
            ST_GATE_REQ: begin
                if (clk_gate_ack) begin
                    w_state_nxt = ST_GATED;
                    w_gate_inc  = 1'b1;
                end
            end
            ST_GATED: begin
                if (w_abort) begin
                    w_state_nxt = ST_UNGATE;
                end
            end
            ST_UNGATE: begin
                if (!clk_gate_ack) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Outputs decode straight from the state register, so reset drops the
    // request asynchronously.
    assign clk_gate_req = (r_state == ST_GATE_REQ) || (r_state == ST_GATED);
    assign chip_gated   = (r_state == ST_GATED);
    assign chip_is_idle = r_chip_is_idle;
    assign gate_cnt     = r_gate_cnt;
    assign state_o      = r_state;

endmodule

// File: tb/tb_chip_idle_ctrl.sv
module tb_chip_idle_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [4:0]  cpu_wfi = '0;
    logic [4:0]  cpu_wfe = '0;
    logic [4:0]  cpu_rstn = '1;
    logic [3:0]  bank_idle = '0;
    logic [3:0]  bank_rstn = '1;
    logic        cfg_en = 1'b1;
    logic [15:0] cfg_idle_thresh = 16'd4;
    logic        wake_irq = 1'b0;
    logic        clk_gate_ack = 1'b0;
    logic        clk_gate_req;
    logic        chip_is_idle;
    logic        chip_gated;
    logic [15:0] gate_cnt;
    logic [2:0]  state_o;

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc;

    always #5 clk = ~clk;

    chip_idle_ctrl dut (
        .clk             (clk),
        .rstn            (rstn),
        .cpu_wfi         (cpu_wfi),
        .cpu_wfe         (cpu_wfe),
        .cpu_rstn        (cpu_rstn),
        .bank_idle       (bank_idle),
        .bank_rstn       (bank_rstn),
        .cfg_en          (cfg_en),
        .cfg_idle_thresh (cfg_idle_thresh),
        .wake_irq        (wake_irq),
        .clk_gate_ack    (clk_gate_ack),
        .clk_gate_req    (clk_gate_req),
        .chip_is_idle    (chip_is_idle),
        .chip_gated      (chip_gated),
        .gate_cnt        (gate_cnt),
        .state_o         (state_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts rising edges until req is seen; returns lim+1 on timeout.
    task automatic wait_req(input int lim, output int n);
        n = lim + 1;
        for (int i = 1; i <= lim; i++) begin
            tick();
            if (clk_gate_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic set_idle_all();
        cpu_wfi   = '1;
        cpu_wfe   = '0;
        cpu_rstn  = '1;
        bank_idle = '1;
        bank_rstn = '1;
    endtask

    task automatic do_reset();
        rstn            = 1'b0;
        clk_gate_ack    = 1'b0;
        wake_irq        = 1'b0;
        cpu_wfi         = '0;
        cpu_wfe         = '0;
        cpu_rstn        = '1;
        bank_idle       = '0;
        bank_rstn       = '1;
        cfg_en          = 1'b1;
        cfg_idle_thresh = 16'd4;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        set_idle_all();
        rstn = 1'b0;
        tick();
        tick();
        n_total++;
        if (state_o !== 3'd0) begin
            n_bad++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
        n_total++;
        if (clk_gate_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_req: got %b want 0", clk_gate_req);
        end
        n_total++;
        if (chip_gated !== 1'b0) begin
            n_bad++; $display("FAIL reset_gated: got %b want 0", chip_gated);
        end
        n_total++;
        if (chip_is_idle !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle: got %b want 0", chip_is_idle);
        end
        n_total++;
        if (gate_cnt !== 16'd0) begin
            n_bad++; $display("FAIL reset_gate_cnt: got %0d want 0", gate_cnt);
        end
    endtask

    task automatic test_basic_gate();
        do_reset();
        set_idle_all();
        wait_req(20, n_cyc);
        n_total++;
        if (n_cyc !== 7) begin
            n_bad++; $display("FAIL idle_to_req_latency: got %0d want 7", n_cyc);
        end
        tick();
        n_total++;
        if ({clk_gate_req, chip_gated, state_o} !== {1'b1, 1'b0, 3'd2}) begin
            n_bad++; $display("FAIL wait_ack: got req=%b gated=%b st=%0d want 1 0 2",
                              clk_gate_req, chip_gated, state_o);
        end
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if ({chip_gated, state_o} !== {1'b1, 3'd3}) begin
            n_bad++; $display("FAIL gated_rise: got gated=%b st=%0d want 1 3", chip_gated, state_o);
        end
        n_total++;
        if (gate_cnt !== 16'd1) begin
            n_bad++; $display("FAIL gate_cnt_first: got %0d want 1", gate_cnt);
        end
    endtask

    // Continues from GATED left by test_basic_gate.
    task automatic test_wake();
        wake_irq = 1'b1;
        tick();
        wake_irq = 1'b0;
        n_total++;
        if ({clk_gate_req, chip_gated, state_o} !== {1'b0, 1'b0, 3'd4}) begin
            n_bad++; $display("FAIL wake_ungate: got req=%b gated=%b st=%0d want 0 0 4",
                              clk_gate_req, chip_gated, state_o);
        end
        tick();
        n_total++;
        if (state_o !== 3'd4) begin
            n_bad++; $display("FAIL ungate_hold: got %0d want 4", state_o);
        end
        clk_gate_ack = 1'b0;
        tick();
        n_total++;
        if (state_o !== 3'd0) begin
            n_bad++; $display("FAIL ungate_to_run: got %0d want 0", state_o);
        end
        wait_req(20, n_cyc);
        n_total++;
        if (n_cyc !== 6) begin
            n_bad++; $display("FAIL regate_latency: got %0d want 6", n_cyc);
        end
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if (gate_cnt !== 16'd2) begin
            n_bad++; $display("FAIL gate_cnt_second: got %0d want 2", gate_cnt);
        end
    endtask

    task automatic test_filter_abort();
        do_reset();
        set_idle_all();
        repeat (4) tick();
        n_total++;
        if (state_o !== 3'd1) begin
            n_bad++; $display("FAIL in_filter: got %0d want 1", state_o);
        end
        cpu_wfi[2] = 1'b0;
        tick();
        n_total++;
        if ({chip_is_idle, state_o} !== {1'b0, 3'd1}) begin
            n_bad++; $display("FAIL abort_lag: got idle=%b st=%0d want 0 1", chip_is_idle, state_o);
        end
        tick();
        n_total++;
        if (state_o !== 3'd0) begin
            n_bad++; $display("FAIL abort_to_run: got %0d want 0", state_o);
        end
        repeat (3) tick();
        n_total++;
        if (clk_gate_req !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_req: got %b want 0", clk_gate_req);
        end
        cpu_wfi[2] = 1'b1;
        wait_req(20, n_cyc);
        n_total++;
        if (n_cyc !== 7) begin
            n_bad++; $display("FAIL refilter_latency: got %0d want 7", n_cyc);
        end
    endtask

    task automatic test_thresh_live();
        do_reset();
        set_idle_all();
        cfg_idle_thresh = 16'd10;
        repeat (4) tick();
        n_total++;
        if (state_o !== 3'd1) begin
            n_bad++; $display("FAIL live_in_filter: got %0d want 1", state_o);
        end
        cfg_idle_thresh = 16'd1;
        tick();
        n_total++;
        if (state_o !== 3'd2) begin
            n_bad++; $display("FAIL live_thresh: got %0d want 2", state_o);
        end
    endtask

    task automatic test_rstn_idle();
        do_reset();
        cpu_wfi   = '0;
        cpu_wfe   = '0;
        cpu_rstn  = '0;
        bank_idle = '0;
        bank_rstn = 4'b0111;
        tick();
        n_total++;
        if (chip_is_idle !== 1'b0) begin
            n_bad++; $display("FAIL bank_active: got %b want 0", chip_is_idle);
        end
        bank_rstn       = '0;
        cfg_idle_thresh = 16'd0;
        tick();
        n_total++;
        if (chip_is_idle !== 1'b1) begin
            n_bad++; $display("FAIL rstn_idle: got %b want 1", chip_is_idle);
        end
        tick();
        n_total++;
        if (state_o !== 3'd1) begin
            n_bad++; $display("FAIL thresh0_filter: got %0d want 1", state_o);
        end
        tick();
        n_total++;
        if ({clk_gate_req, state_o} !== {1'b1, 3'd2}) begin
            n_bad++; $display("FAIL thresh0_req: got req=%b st=%0d want 1 2", clk_gate_req, state_o);
        end
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if ({chip_gated, gate_cnt} !== {1'b1, 16'd1}) begin
            n_bad++; $display("FAIL rstn_gated: got gated=%b cnt=%0d want 1 1", chip_gated, gate_cnt);
        end
        cpu_rstn = '1;
        cpu_wfe  = '1;
        tick();
        n_total++;
        if (chip_is_idle !== 1'b1) begin
            n_bad++; $display("FAIL wfe_idle: got %b want 1", chip_is_idle);
        end
    endtask

    task automatic test_wake_in_req();
        do_reset();
        set_idle_all();
        cfg_idle_thresh = 16'd0;
        wait_req(10, n_cyc);
        n_total++;
        if (n_cyc !== 3) begin
            n_bad++; $display("FAIL thresh0_latency: got %0d want 3", n_cyc);
        end
        wake_irq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({clk_gate_req, state_o} !== {1'b1, 3'd2}) begin
                n_bad++; $display("FAIL req_held_%0d: got req=%b st=%0d want 1 2", i, clk_gate_req, state_o);
            end
        end
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if ({chip_gated, state_o, gate_cnt} !== {1'b1, 3'd3, 16'd1}) begin
            n_bad++; $display("FAIL late_ack_gated: got gated=%b st=%0d cnt=%0d want 1 3 1",
                              chip_gated, state_o, gate_cnt);
        end
        tick();
        n_total++;
        if ({clk_gate_req, state_o} !== {1'b0, 3'd4}) begin
            n_bad++; $display("FAIL late_ack_ungate: got req=%b st=%0d want 0 4", clk_gate_req, state_o);
        end
        wake_irq     = 1'b0;
        clk_gate_ack = 1'b0;
        tick();
        n_total++;
        if (state_o !== 3'd0) begin
            n_bad++; $display("FAIL late_ack_run: got %0d want 0", state_o);
        end
    endtask

    task automatic test_wake_ack_same();
        do_reset();
        set_idle_all();
        cfg_idle_thresh = 16'd0;
        wait_req(10, n_cyc);
        wake_irq     = 1'b1;
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if ({state_o, gate_cnt} !== {3'd3, 16'd1}) begin
            n_bad++; $display("FAIL same_cycle_gated: got st=%0d cnt=%0d want 3 1", state_o, gate_cnt);
        end
        tick();
        n_total++;
        if ({clk_gate_req, state_o} !== {1'b0, 3'd4}) begin
            n_bad++; $display("FAIL same_cycle_ungate: got req=%b st=%0d want 0 4", clk_gate_req, state_o);
        end
        wake_irq     = 1'b0;
        clk_gate_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_idle_all();
        cfg_idle_thresh = 16'd0;
        wait_req(10, n_cyc);
        clk_gate_ack = 1'b1;
        tick();
        n_total++;
        if (state_o !== 3'd3) begin
            n_bad++; $display("FAIL pre_reset_gated: got %0d want 3", state_o);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_total++;
        if ({clk_gate_req, chip_gated, chip_is_idle, state_o, gate_cnt} !== 22'd0) begin
            n_bad++; $display("FAIL async_reset: got req=%b gated=%b idle=%b st=%0d cnt=%0d want all 0",
                              clk_gate_req, chip_gated, chip_is_idle, state_o, gate_cnt);
        end
        cfg_en = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        n_total++;
        if ({clk_gate_req, state_o} !== {1'b0, 3'd0}) begin
            n_bad++; $display("FAIL spurious_ack_run: got req=%b st=%0d want 0 0", clk_gate_req, state_o);
        end
        cfg_en = 1'b1;
        tick();
        n_total++;
        if (state_o !== 3'd1) begin
            n_bad++; $display("FAIL spurious_ack_filter: got %0d want 1", state_o);
        end
        tick();
        n_total++;
        if (state_o !== 3'd2) begin
            n_bad++; $display("FAIL post_reset_req: got %0d want 2", state_o);
        end
        tick();
        n_total++;
        if ({state_o, gate_cnt} !== {3'd3, 16'd1}) begin
            n_bad++; $display("FAIL post_reset_gated: got st=%0d cnt=%0d want 3 1", state_o, gate_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic_gate();
        test_wake();
        test_filter_abort();
        test_thresh_live();
        test_rstn_idle();
        test_wake_in_req();
        test_wake_ack_same();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
